// File: rtl/uart_rx_if.sv
// Bus between the UART receiver, its stimulus side (pad + baud tick) and the RX FIFO.
// master drives line/tick/full; slave (the receiver) drives the received word and status.
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            fifo_full;
  logic [DBIT-1:0] rx_data;
  logic            rx_wr;
  logic            frame_err;
  logic            overrun_err;
  logic            busy;

  modport master (
    output rx, s_tick, fifo_full,
    input  rx_data, rx_wr, frame_err, overrun_err, busy
  );

  modport slave (
    input  rx, s_tick, fifo_full,
    output rx_data, rx_wr, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: samples rx mid-bit, shifts DBIT bits LSB first and
// writes good words to the RX FIFO, flagging framing and overrun errors.
module uart_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned SW    = $clog2(S_MAX);
  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            wr_q, wr_d;
  logic            ferr_q, ferr_d;
  logic            oerr_q, oerr_d;
  logic            busy_q, busy_d;
  logic            lock_q, lock_d;
  logic [1:0]      sync_q;
  logic            rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    lock_d  = lock_q;

    unique case (state_q)
      IDLE: begin
        // After a framing error the line must go high once before a new start is armed.
        if (lock_q) begin
          if (rx_s) lock_d = 1'b0;
        end else if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            n_d = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            s_d     = '0;
            if (!rx_s) begin
              ferr_d = 1'b1;
              lock_d = 1'b1;
            end else if (bus.fifo_full) begin
              oerr_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = b_q;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_wr       = wr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = oerr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames with hand-picked bytes, glitch, framing,
// overrun, back-to-back, slow-tick and mid-frame reset cases.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tick_div = 1;
  int   tick_cnt = 0;

  int   n_cmp = 0;
  int   n_bad = 0;

  int        wr_cnt = 0;
  int        ferr_cnt = 0;
  int        oerr_cnt = 0;
  int        busy_cnt = 0;
  int        multi_cnt = 0;
  logic [7:0] last_data = 8'h00;
  int        last_wr_cyc = 0;
  int        fall_cyc = 0;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT(8),
    .OVERSAMPLE(16),
    .SB_TICK(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: every clk when tick_div = 1, else one pulse per tick_div clks.
  always @(negedge clk) begin
    if (tick_div <= 1) begin
      bus.s_tick = 1'b1;
    end else begin
      bus.s_tick = (tick_cnt == 0);
      tick_cnt   = (tick_cnt + 1) % tick_div;
    end
  end

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_wr) begin
      wr_cnt++;
      last_data   = bus.rx_data;
      last_wr_cyc = cyc;
    end
    if (bus.frame_err)   ferr_cnt++;
    if (bus.overrun_err) oerr_cnt++;
    if (bus.busy)        busy_cnt++;
    if ((int'(bus.rx_wr) + int'(bus.frame_err) + int'(bus.overrun_err)) > 1) multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // full_mode: 0 = fifo not full, 1 = full for whole frame, 2 = full only before the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int full_mode);
    int bit_clks;
    bit_clks      = 16 * tick_div;
    bus.fifo_full = (full_mode != 0);
    bus.rx        = 1'b0;
    fall_cyc      = cyc;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (full_mode == 2) bus.fifo_full = 1'b0;
    bus.rx = stop;
    repeat (bit_clks) @(negedge clk);
    bus.fifo_full = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got cycle %0d expected under 20000", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w0, f0, o0, b0, lat;
    bus.rx        = 1'b1;
    bus.fifo_full = 1'b0;
    rst           = 1'b1;
    idle(3);
    check("rst_rx_wr", 32'(bus.rx_wr), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun_err", 32'(bus.overrun_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    rst = 1'b0;
    idle(5);

    // Basic receive with latency window 154 +/- 1.
    w0 = wr_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    send_frame(8'hA5, 1'b1, 0);
    idle(4);
    check("basic_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check("basic_data", 32'(last_data), 32'hA5);
    lat = last_wr_cyc - fall_cyc;
    check("basic_latency", 32'((lat >= 153 && lat <= 155) ? 154 : lat), 32'd154);
    check("basic_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("basic_oerr", 32'(oerr_cnt - o0), 32'd0);

    // Glitch rejection.
    w0 = wr_cnt; f0 = ferr_cnt; o0 = oerr_cnt; b0 = busy_cnt;
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    idle(20);
    check("glitch_busy_seen", 32'(busy_cnt != b0), 32'd1);
    check("glitch_busy_end", 32'(bus.busy), 32'd0);
    check("glitch_pulses", 32'((wr_cnt - w0) + (ferr_cnt - f0) + (oerr_cnt - o0)), 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    idle(4);
    check("glitch_next_cnt", 32'(wr_cnt - w0), 32'd1);
    check("glitch_next_data", 32'(last_data), 32'h3C);

    // Framing error, line held low afterwards.
    w0 = wr_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 0);
    b0 = busy_cnt;
    idle(200);
    check("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("ferr_low_no_start", 32'(busy_cnt - b0), 32'd0);
    bus.rx = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 0);
    idle(4);
    check("ferr_next_cnt", 32'(wr_cnt - w0), 32'd1);
    check("ferr_next_data", 32'(last_data), 32'h81);

    // Overrun: fifo full at the final stop tick.
    w0 = wr_cnt; o0 = oerr_cnt; f0 = ferr_cnt;
    send_frame(8'h7E, 1'b1, 1);
    idle(4);
    check("ovr_oerr", 32'(oerr_cnt - o0), 32'd1);
    check("ovr_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("ovr_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("ovr_data_held", 32'(bus.rx_data), 32'h81);
    send_frame(8'h7F, 1'b1, 0);
    idle(4);
    check("ovr_next_data", 32'(last_data), 32'h7F);

    // fifo_full high during data bits only: must still write.
    w0 = wr_cnt; o0 = oerr_cnt;
    send_frame(8'h96, 1'b1, 2);
    idle(4);
    check("early_full_wr", 32'(wr_cnt - w0), 32'd1);
    check("early_full_oerr", 32'(oerr_cnt - o0), 32'd0);
    check("early_full_data", 32'(last_data), 32'h96);

    // Back-to-back frames with no idle gap.
    w0 = wr_cnt;
    send_frame(8'h00, 1'b1, 0);
    check("b2b_first_data", 32'(last_data), 32'h00);
    check("b2b_first_cnt", 32'(wr_cnt - w0), 32'd1);
    send_frame(8'hFF, 1'b1, 0);
    idle(4);
    check("b2b_second_data", 32'(last_data), 32'hFF);
    check("b2b_total_cnt", 32'(wr_cnt - w0), 32'd2);

    // Tick every other clk.
    tick_div = 2;
    idle(4);
    w0 = wr_cnt;
    send_frame(8'h6B, 1'b1, 0);
    idle(4);
    check("slow_tick_cnt", 32'(wr_cnt - w0), 32'd1);
    check("slow_tick_data", 32'(last_data), 32'h6B);
    tick_div = 1;
    idle(4);

    // Reset in the middle of data bit 4, held until the frame ends.
    w0 = wr_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        idle(16 * 5 + 8);
        rst = 1'b1;
        idle(1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("mid_rst_pulses", 32'({bus.rx_wr, bus.frame_err, bus.overrun_err}), 32'd0);
      end
    join
    idle(2);
    rst = 1'b0;
    idle(10);
    check("mid_rst_no_out", 32'((wr_cnt - w0) + (ferr_cnt - f0) + (oerr_cnt - o0)), 32'd0);
    send_frame(8'h5A, 1'b1, 0);
    idle(4);
    check("post_rst_cnt", 32'(wr_cnt - w0), 32'd1);
    check("post_rst_data", 32'(last_data), 32'h5A);

    check("one_hot_pulses", 32'(multi_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
